simple_dual_ram_clr: RTL and testbench
======================================

// Module: simple_dual_ram_clr
// PURPOSE
//   Single-clock simple dual-port RAM: one write port, one read port.
//   Adds per-lane write enables and a read enable with a valid flag.
//   Adds a write-first bypass for same-address collisions.
//   After every reset, a sweep sets all entries to INIT_VALUE before the RAM accepts traffic.
//   Used as the general storage primitive for buffers, FIFOs and lookup tables that need a known initial state.
// PARAMETERS
//   SIZE        8    word width in bits; must be a multiple of LANES
//   DEPTH       64   number of entries, >= 2; need not be a power of two
//   LANES       1    write-enable lanes; lane width LW = SIZE/LANES
//   INIT_VALUE  0    SIZE-bit value written to every entry by the clear sweep
// PORTS
//   clk         in   1              clock
//   rst         in   1              synchronous reset, active-high
//   waddr       in   $clog2(DEPTH)  write address
//   write_data  in   SIZE           write data
//   write_en    in   LANES          lane i writes bits [i*LW +: LW]
//   raddr       in   $clog2(DEPTH)  read address
//   read_en     in   1              read request
//   read_data   out  SIZE           read result, registered
//   read_valid  out  1              read_data updated this cycle from a request
//   busy        out  1              clear sweep in progress; user ports are ignored
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state<=CLEAR, clr_addr<=0, busy<=1, read_data<=0, read_valid<=0.
//   - rst has priority over all other inputs in every state.
//   - CLEAR state, one entry per cycle:
//       * mem[clr_addr]<=INIT_VALUE, then clr_addr++.
//       * On the cycle clr_addr==DEPTH-1: state<=READY and busy<=0.
//       * The sweep therefore takes exactly DEPTH cycles after rst deasserts.
//       * write_en and read_en are ignored; read_valid stays 0.
//   - READY state, writes:
//       * For each lane i with write_en[i]=1: mem[waddr][lane i]<=write_data[lane i].
//       * Lanes with write_en[i]=0 keep their contents.
//   - READY state, reads:
//       * read_en=1: the next cycle gives read_data=mem[raddr] and read_valid=1 (latency 1).
//       * read_en=0: the next cycle gives read_valid=0, and read_data holds its last value.
//   - Collision (read_en=1, any write_en bit set, raddr==waddr, same cycle): write-first.
//       * Enabled lanes return the new write_data.
//       * Disabled lanes return the old contents.
//   - Out of range (address >= DEPTH, only possible when DEPTH is not a power of two):
//       * Writes are dropped.
//       * Reads return INIT_VALUE with read_valid=1.
//   - Reset mid-operation (either state):
//       * Aborts any read in flight; read_valid=0 on the next cycle.
//       * Restarts the sweep from address 0, so the previous contents are cleared.
//   - Storage is a plain mem array with no reset, so synthesis maps it to block RAM.
//     Only the control registers and output registers are reset.
//   - State encoding: CLEAR=0, READY=1. There are no other states.
// CONFIGURATION
//   SIMPLE_DUAL_RAM_CLR_OUTREG_EN defined:
//     - Adds a second output register stage.
//     - Read latency becomes 2; read_valid is delayed to match.
//     - The collision bypass still applies, to the data captured in stage 1.
//     - Both stages reset to 0/invalid.
//     - Back-to-back reads stream at one per cycle.
//   Macro not defined:
//     - Single output register; read latency is 1.
// TESTING
//   1. Reset sweep: DEPTH=64. Pulse rst for 1 cycle.
//      -> busy=1 for exactly 64 cycles.
//      -> Reads of addr 0, 31 and 63 then return INIT_VALUE with read_valid=1.
//   2. Basic read/write: write 0xA5 to addr 5, idle 1 cycle, then read_en=1 with raddr=5.
//      -> read_data=0xA5 and read_valid=1 one cycle later (two cycles later with OUTREG_EN).
//   3. Lane masking: SIZE=16, LANES=2. Write 0x1234 to addr 9 with write_en=2'b11,
//      then write 0xABCD with write_en=2'b01.
//      -> A read of addr 9 returns 0x12CD.
//   4. Collision: mem[3]=0x00FF, SIZE=16, LANES=2. Same cycle: write 0xAA55 to addr 3
//      with write_en=2'b10, and read addr 3.
//      -> read_data=0xAAFF.
//      -> A read of addr 3 on the following cycle also returns 0xAAFF.
//   5. Ignored during sweep: assert write_en and read_en while busy=1.
//      -> read_valid stays 0.
//      -> After the sweep, every targeted address reads INIT_VALUE.
//   6. Reset mid-read: issue read_en=1 and assert rst in the next cycle.
//      -> read_valid=0 and read_data=0.
//      -> busy=1 and the full DEPTH-cycle sweep restarts; data written earlier now reads INIT_VALUE.

Source files
------------

// File: rtl/simple_dual_ram_clr.sv
// Single-clock simple dual-port RAM with lane write enables, write-first bypass and a clear sweep
// after every reset. Define SIMPLE_DUAL_RAM_CLR_OUTREG_EN for a second output register stage.
module simple_dual_ram_clr #(
    parameter int unsigned     SIZE       = 8,
    parameter int unsigned     DEPTH      = 64,
    parameter int unsigned     LANES      = 1,
    parameter logic [SIZE-1:0] INIT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [SIZE-1:0]          write_data,
    input  logic [LANES-1:0]         write_en,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     read_en,
    output logic [SIZE-1:0]          read_data,
    output logic                     read_valid,
    output logic                     busy
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned LW      = SIZE / LANES;
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    typedef enum logic [0:0] {
        StClear = 1'b0,
        StReady = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic            busy_q, busy_d;

    logic [SIZE-1:0] mem [DEPTH];

    logic [LANES-1:0] mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [SIZE-1:0]  mem_wdata;
    logic             waddr_ok, raddr_ok, rd_req;
    logic [SIZE-1:0]  rd_word;

    assign waddr_ok = {1'b0, waddr} < DEPTH_W;
    assign raddr_ok = {1'b0, raddr} < DEPTH_W;
    assign rd_req   = !rst && (state_q == StReady) && read_en;

    // The sweep and user writes share the single physical write port.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        busy_d     = busy_q;
        mem_we     = '0;
        mem_waddr  = waddr;
        mem_wdata  = write_data;
        unique case (state_q)
            StClear: begin
                mem_we     = '1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = INIT_VALUE;
                clr_addr_d = clr_addr_q + AW'(1);
                if (clr_addr_q == AW'(DEPTH - 1)) begin
                    state_d = StReady;
                    busy_d  = 1'b0;
                end
            end
            StReady: begin
                if (waddr_ok) mem_we = write_en;
            end
            default: ;
        endcase
        if (rst) mem_we = '0;
    end

    // Write-first: enabled lanes of a same-address write replace the stored lanes.
    always_comb begin
        rd_word = INIT_VALUE;
        if (raddr_ok) begin
            rd_word = mem[raddr];
            for (int i = 0; i < LANES; i++) begin
                if (write_en[i] && (waddr == raddr)) rd_word[i*LW +: LW] = write_data[i*LW +: LW];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (mem_we[i]) mem[mem_waddr][i*LW +: LW] <= mem_wdata[i*LW +: LW];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    logic [SIZE-1:0] s1_data_q;
    logic            s1_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= rd_req;
            if (rd_req) s1_data_q <= rd_word;
        end
    end

`ifdef SIMPLE_DUAL_RAM_CLR_OUTREG_EN
    logic [SIZE-1:0] s2_data_q;
    logic            s2_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_data_q  <= '0;
            s2_valid_q <= 1'b0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) s2_data_q <= s1_data_q;
        end
    end

    assign read_data  = s2_data_q;
    assign read_valid = s2_valid_q;
`else
    assign read_data  = s1_data_q;
    assign read_valid = s1_valid_q;
`endif

    assign busy = busy_q;

endmodule

// File: tb/tb_simple_dual_ram_clr.sv
// Self-checking bench for simple_dual_ram_clr: directed vector table, corner sequences and
// randomized traffic against a memory-array reference model.
module tb_simple_dual_ram_clr;

    localparam int unsigned SIZE  = 16;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LANES = 2;
    localparam logic [15:0] INIT  = 16'h5A3C;
`ifdef SIMPLE_DUAL_RAM_CLR_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, read_en, read_valid, busy;
    logic [5:0]  waddr, raddr;
    logic [15:0] write_data, read_data;
    logic [1:0]  write_en;

    simple_dual_ram_clr #(
        .SIZE(SIZE), .DEPTH(DEPTH), .LANES(LANES), .INIT_VALUE(INIT)
    ) u_dut (
        .clk(clk), .rst(rst), .waddr(waddr), .write_data(write_data), .write_en(write_en),
        .raddr(raddr), .read_en(read_en), .read_data(read_data), .read_valid(read_valid),
        .busy(busy)
    );

    // Non-power-of-two depth instance for out-of-range behaviour.
    logic       b_rst, b_we, b_re, b_rvalid, b_busy;
    logic [2:0] b_waddr, b_raddr;
    logic [7:0] b_wdata, b_rdata;

    simple_dual_ram_clr #(
        .SIZE(8), .DEPTH(6), .LANES(1), .INIT_VALUE(8'hC3)
    ) u_dut_b (
        .clk(clk), .rst(b_rst), .waddr(b_waddr), .write_data(b_wdata), .write_en(b_we),
        .raddr(b_raddr), .read_en(b_re), .read_data(b_rdata), .read_valid(b_rvalid),
        .busy(b_busy)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain memory array plus a LAT-deep delay line of read results.
    logic [15:0] mem_m [DEPTH];
    int          busy_left;
    logic        pipe_v [LAT];
    logic [15:0] pipe_d [LAT];
    logic [15:0] last_d;

    task automatic step(input logic r, input logic [1:0] we, input logic [5:0] wa,
                        input logic [15:0] wd, input logic re, input logic [5:0] ra);
        logic        nv;
        logic [15:0] nd;
        rst = r; write_en = we; waddr = wa; write_data = wd; read_en = re; raddr = ra;
        nv = 1'b0;
        nd = '0;
        if (r) begin
            busy_left = DEPTH;
            foreach (mem_m[i]) mem_m[i] = INIT;
            for (int i = 0; i < LAT; i++) begin
                pipe_v[i] = 1'b0;
                pipe_d[i] = '0;
            end
            last_d = '0;
        end else begin
            if (busy_left > 0) begin
                busy_left--;
            end else begin
                if (we[1]) mem_m[wa][15:8] = wd[15:8];
                if (we[0]) mem_m[wa][7:0]  = wd[7:0];
                nv = re;
                nd = mem_m[ra];
            end
            for (int i = LAT - 1; i > 0; i--) begin
                pipe_v[i] = pipe_v[i-1];
                pipe_d[i] = pipe_d[i-1];
            end
            pipe_v[0] = nv;
            pipe_d[0] = nd;
            if (pipe_v[LAT-1]) last_d = pipe_d[LAT-1];
        end
        @(posedge clk);
        #1;
        check("busy", busy, busy_left > 0);
        check("read_valid", read_valid, pipe_v[LAT-1]);
        check("read_data", read_data, last_d);
    endtask

    task automatic idle();
        step(1'b0, 2'b00, 6'd0, 16'h0, 1'b0, 6'd0);
    endtask

    task automatic read_and_check(input string name, input logic [5:0] ra,
                                  input logic [15:0] exp);
        step(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, ra);
        repeat (LAT - 1) idle();
        check({name, " data"}, read_data, exp);
        check({name, " valid"}, read_valid, 1'b1);
    endtask

    task automatic sweep_len(input string name);
        int n;
        n = busy ? 1 : 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            idle();
            if (!busy) break;
            n++;
        end
        check(name, n, DEPTH);
    endtask

    task automatic b_cyc(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                         input logic re, input logic [2:0] ra);
        b_we = we; b_waddr = wa; b_wdata = wd; b_re = re; b_raddr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic b_read(input string name, input logic [2:0] ra, input logic [7:0] exp);
        b_cyc(1'b0, 3'd0, 8'h0, 1'b1, ra);
        repeat (LAT - 1) b_cyc(1'b0, 3'd0, 8'h0, 1'b0, 3'd0);
        check({name, " data"}, b_rdata, exp);
        check({name, " valid"}, b_rvalid, 1'b1);
        b_cyc(1'b0, 3'd0, 8'h0, 1'b0, 3'd0);
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [5:0]  wa;
        logic [15:0] wd;
        logic [5:0]  ra;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic        r_r, re_r, hit;
        logic [1:0]  we_r;
        logic [5:0]  wa_r, ra_r;
        logic [15:0] wd_r;
        int          n;

        vecs[0] = '{2'b00, 6'd0,  16'h0000, 6'd0,  16'h5A3C};
        vecs[1] = '{2'b00, 6'd0,  16'h0000, 6'd31, 16'h5A3C};
        vecs[2] = '{2'b00, 6'd0,  16'h0000, 6'd63, 16'h5A3C};
        vecs[3] = '{2'b11, 6'd5,  16'h00A5, 6'd5,  16'h00A5};
        vecs[4] = '{2'b11, 6'd9,  16'h1234, 6'd9,  16'h1234};
        vecs[5] = '{2'b01, 6'd9,  16'hABCD, 6'd9,  16'h12CD};
        vecs[6] = '{2'b10, 6'd9,  16'h7700, 6'd9,  16'h77CD};
        vecs[7] = '{2'b10, 6'd20, 16'hBEEF, 6'd20, 16'hBE3C};
        vecs[8] = '{2'b11, 6'd63, 16'hFFFF, 6'd63, 16'hFFFF};
        vecs[9] = '{2'b01, 6'd0,  16'h1111, 6'd0,  16'h5A11};

        b_rst = 1'b1; b_we = 1'b0; b_re = 1'b0; b_waddr = '0; b_raddr = '0; b_wdata = '0;

        // Reset and sweep length.
        step(1'b1, 2'b00, 6'd0, 16'h0, 1'b0, 6'd0);
        step(1'b1, 2'b00, 6'd0, 16'h0, 1'b0, 6'd0);
        sweep_len("sweep_len_initial");

        // Directed write / idle / read vectors.
        for (int k = 0; k < 10; k++) begin
            step(1'b0, vecs[k].we, vecs[k].wa, vecs[k].wd, 1'b0, 6'd0);
            idle();
            read_and_check($sformatf("vec%0d", k), vecs[k].ra, vecs[k].exp);
        end

        // Same-address collision, then a follow-up read.
        step(1'b0, 2'b11, 6'd3, 16'h00FF, 1'b0, 6'd0);
        step(1'b0, 2'b10, 6'd3, 16'hAA55, 1'b1, 6'd3);
        step(1'b0, 2'b00, 6'd0, 16'h0000, 1'b1, 6'd3);
        check("collision data", read_data, 16'hAAFF);
        check("collision valid", read_valid, 1'b1);
        idle();
        check("collision reread data", read_data, 16'hAAFF);

        // Reset mid-read clears outputs and restarts the sweep.
        step(1'b0, 2'b11, 6'd40, 16'h1357, 1'b0, 6'd0);
        idle();
        step(1'b0, 2'b00, 6'd0, 16'h0, 1'b1, 6'd40);
        step(1'b1, 2'b00, 6'd0, 16'h0, 1'b0, 6'd0);
        check("midreset valid", read_valid, 1'b0);
        check("midreset data", read_data, 16'h0);
        check("midreset busy", busy, 1'b1);
        sweep_len("sweep_len_midreset");
        read_and_check("midreset cleared", 6'd40, INIT);

        // Traffic on low addresses late in the sweep must be ignored.
        step(1'b1, 2'b00, 6'd0, 16'h0, 1'b0, 6'd0);
        for (int i = 0; i < DEPTH && busy_left > 10; i++) idle();
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 2'b11, 6'(k), 16'(16'hC000 + k), 1'b1, 6'(k));
            check($sformatf("sweep ignore valid%0d", k), read_valid, 1'b0);
        end
        for (int k = 0; k < 10; k++) read_and_check($sformatf("post sweep%0d", k), 6'(k), INIT);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            r_r  = ($urandom_range(0, 299) == 0);
            we_r = 2'($urandom);
            wa_r = 6'($urandom_range(0, 15));
            wd_r = 16'($urandom);
            re_r = 1'($urandom);
            hit  = 1'($urandom);
            ra_r = hit ? wa_r : 6'($urandom_range(0, 15));
            step(r_r, we_r, wa_r, wd_r, re_r, ra_r);
        end
        repeat (LAT + 1) idle();

        // Out-of-range addresses on the depth-6 instance.
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && b_busy; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b sweep_len", n, 6);
        b_cyc(1'b1, 3'd7, 8'h11, 1'b0, 3'd0);
        b_cyc(1'b1, 3'd5, 8'h22, 1'b0, 3'd0);
        b_cyc(1'b1, 3'd6, 8'h33, 1'b0, 3'd0);
        b_cyc(1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
        b_read("b oor7", 3'd7, 8'hC3);
        b_read("b oor6", 3'd6, 8'hC3);
        b_read("b addr5", 3'd5, 8'h22);
        b_read("b addr0", 3'd0, 8'hC3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
